// File: rtl/alu_arbiter.sv
// alu_arbiter: arbiter and sequencer for the shared 16-bit ALU.
// Two requesters issue operations over valid/ready. One operation runs at a
// time. The block drives the ALU inputs (ctrl/a/b) and holds them through the
// ALU's registered result cycle. It then returns y and flags to the owning
// requester, and updates the global status register.
//
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o [1:0] request handshake, bit i = requester i
//   reqN_op_i/reqN_a_i/reqN_b_i   opcode and operands of requester N
//   rsp_valid_o/rsp_ready_i [1:0] response handshake, bit i = requester i
//   rsp_y_o, rsp_flags_o          result and {s,v,n,z,c} of the response
//   alu_ctrl_o/alu_a_o/alu_b_o    registered ALU inputs
//   alu_y_i, alu_{c,z,n,v,s}_i    ALU result and flags
//   sreg_o                        {s,v,n,z,c} of the last completed operation
//   busy_o, owner_o               not IDLE; current or last granted requester
module alu_arbiter #(
  parameter logic RR_EN        = 1'b1,
  parameter int   STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [3:0]  req0_op_i,
  input  logic [3:0]  req1_op_i,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req0_b_i,
  input  logic [15:0] req1_b_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [15:0] rsp_y_o,
  output logic [4:0]  rsp_flags_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  input  logic [15:0] alu_y_i,
  input  logic        alu_c_i,
  input  logic        alu_z_i,
  input  logic        alu_n_i,
  input  logic        alu_v_i,
  input  logic        alu_s_i,
  output logic [4:0]  sreg_o,
  output logic        busy_o,
  output logic        owner_o
);

  localparam logic [3:0] ALU_OP_MUL = 4'h7;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [3:0]  starve_q;
  logic [3:0]  alu_ctrl_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [1:0]  rsp_valid_q;
  logic [15:0] rsp_y_q;
  logic [4:0]  rsp_flags_q;
  logic [4:0]  sreg_q;

  logic        gnt;
  logic [4:0]  cap_flags;

  // Grant selection. On a tie, the starve counter overrides requester 0's
  // priority once it reaches the limit.
  always_comb begin
    gnt         = 1'b0;
    req_ready_o = 2'b00;
    if (&req_valid_i) begin
      if (RR_EN) gnt = ~last_grant_q;
      else       gnt = (starve_q == LIMIT);
    end else begin
      gnt = req_valid_i[1];
    end
    if (state_q == IDLE && |req_valid_i) req_ready_o[gnt] = 1'b1;
  end

  // The ALU leaves c/v undefined for multiply. Force them to 0, so s = n.
  always_comb begin
    cap_flags = {alu_s_i, alu_v_i, alu_n_i, alu_z_i, alu_c_i};
    if (alu_ctrl_q == ALU_OP_MUL) cap_flags = {alu_n_i, 1'b0, alu_n_i, alu_z_i, 1'b0};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      starve_q     <= 4'd0;
      alu_ctrl_q   <= 4'h0;
      alu_a_q      <= 16'h0;
      alu_b_q      <= 16'h0;
      rsp_valid_q  <= 2'b00;
      rsp_y_q      <= 16'h0;
      rsp_flags_q  <= 5'h0;
      sreg_q       <= 5'h0;
    end else begin
      case (state_q)
        IDLE: begin
          // Any valid request in IDLE is a handshake with the granted side.
          if (|req_valid_i) begin
            alu_ctrl_q   <= gnt ? req1_op_i : req0_op_i;
            alu_a_q      <= gnt ? req1_a_i  : req0_a_i;
            alu_b_q      <= gnt ? req1_b_i  : req0_b_i;
            owner_q      <= gnt;
            last_grant_q <= gnt;
            if (gnt)                                  starve_q <= 4'd0;
            else if (req_valid_i[1] && starve_q != 4'hF) starve_q <= starve_q + 4'd1;
            state_q      <= EXEC;
          end
        end
        EXEC: state_q <= CAPT;
        CAPT: begin
          rsp_y_q              <= alu_y_i;
          rsp_flags_q          <= cap_flags;
          sreg_q               <= cap_flags;
          rsp_valid_q[owner_q] <= 1'b1;
          state_q              <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_ctrl_o  = alu_ctrl_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_y_o     = rsp_y_q;
  assign rsp_flags_o = rsp_flags_q;
  assign sreg_o      = sreg_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (round-robin and fixed priority),
// each driving its own behavioural ALU. A transaction-level model predicts
// every output on every cycle. Directed cases pin literal results and grant
// orders. Randomized traffic follows.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                         OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_MUL = 4'h7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [1:0]  req_valid[2], req_ready[2], rsp_valid[2], rsp_ready[2];
  logic [3:0]  op[2][2];
  logic [15:0] opa[2][2], opb[2][2];
  logic [15:0] rsp_y[2];
  logic [4:0]  rsp_flags[2], sreg[2];
  logic [3:0]  alu_ctrl[2];
  logic [15:0] alu_a[2], alu_b[2];
  logic        busy[2], owner[2];

  // ALU behaviour: returns {c, v, y}. Reserved opcodes give zero. Multiply
  // reports junk c/v, so the arbiter has to mask them.
  function automatic logic [17:0] ref_alu(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 16'h0;
    case (o)
      OP_ADD: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16]; v = (x[15] == y[15]) && (r[15] != x[15]); end
      OP_SUB: begin r = x - y; c = (x < y); v = (x[15] != y[15]) && (r[15] != x[15]); end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: begin r = x << 1; c = x[15]; end
      OP_SHR: begin r = x >> 1; c = x[0]; end
      OP_MUL: begin p = x * y; r = p[15:0]; c = |p[31:16]; v = 1'b1; end
      default: ;
    endcase
    return {c, v, r};
  endfunction

  // Expected response: {y, s, v, n, z, c}.
  function automatic logic [20:0] exp_rsp(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [17:0] t;
    logic c, v, n, z;
    t = ref_alu(o, x, y);
    c = t[17]; v = t[16];
    if (o == OP_MUL) begin c = 1'b0; v = 1'b0; end
    n = t[15]; z = (t[15:0] == 16'h0);
    return {t[15:0], n ^ v, v, n, z, c};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom % 5)
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] yq;
    logic [17:0] cv;
    always_comb cv = ref_alu(alu_ctrl[g], alu_a[g], alu_b[g]);
    always @(posedge clk) yq <= cv[15:0];

    alu_arbiter #(.RR_EN(g == 0 ? 1'b1 : 1'b0), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .resetn(resetn),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
      .req0_op_i(op[g][0]), .req1_op_i(op[g][1]),
      .req0_a_i(opa[g][0]), .req1_a_i(opa[g][1]),
      .req0_b_i(opb[g][0]), .req1_b_i(opb[g][1]),
      .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
      .rsp_y_o(rsp_y[g]), .rsp_flags_o(rsp_flags[g]),
      .alu_ctrl_o(alu_ctrl[g]), .alu_a_o(alu_a[g]), .alu_b_o(alu_b[g]),
      .alu_y_i(yq), .alu_c_i(cv[17]), .alu_z_i(yq == 16'h0), .alu_n_i(yq[15]),
      .alu_v_i(cv[16]), .alu_s_i(yq[15] ^ cv[16]),
      .sreg_o(sreg[g]), .busy_o(busy[g]), .owner_o(owner[g])
    );
  end

  // Transaction model: one op in flight, m_age counts edges since acceptance.
  // The response is due from age 2 onward.
  logic        m_busy[2], m_own[2], m_last[2];
  int          m_age[2], m_starve[2];
  logic [3:0]  m_ctrl[2];
  logic [15:0] m_a[2], m_b[2];
  logic [20:0] m_rsp[2];
  logic [4:0]  m_sreg[2];
  int          glog[2][$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [1:0] er, ev;
      logic pk;
      if (!resetn) begin
        m_busy[k] = 1'b0; m_own[k] = 1'b0; m_last[k] = 1'b1; m_age[k] = 0; m_starve[k] = 0;
        m_ctrl[k] = 4'h0; m_a[k] = 16'h0; m_b[k] = 16'h0; m_sreg[k] = 5'h0; m_rsp[k] = 21'h0;
      end
      if (&req_valid[k]) pk = (k == 0) ? ~m_last[k] : (m_starve[k] == 4);
      else               pk = req_valid[k][1];
      er = 2'b00;
      if (!m_busy[k] && |req_valid[k]) er[pk] = 1'b1;
      ev = 2'b00;
      if (m_busy[k] && m_age[k] >= 2) ev[m_own[k]] = 1'b1;
      chk($sformatf("i%0d_req_ready", k), 32'(req_ready[k]), 32'(er));
      chk($sformatf("i%0d_busy", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("i%0d_owner", k), 32'(owner[k]), 32'(m_own[k]));
      chk($sformatf("i%0d_alu_ctrl", k), 32'(alu_ctrl[k]), 32'(m_ctrl[k]));
      chk($sformatf("i%0d_alu_a", k), 32'(alu_a[k]), 32'(m_a[k]));
      chk($sformatf("i%0d_alu_b", k), 32'(alu_b[k]), 32'(m_b[k]));
      chk($sformatf("i%0d_sreg", k), 32'(sreg[k]), 32'(m_sreg[k]));
      chk($sformatf("i%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'(ev));
      if (ev != 2'b00) begin
        chk($sformatf("i%0d_rsp_y", k), 32'(rsp_y[k]), 32'(m_rsp[k][20:5]));
        chk($sformatf("i%0d_rsp_flags", k), 32'(rsp_flags[k]), 32'(m_rsp[k][4:0]));
      end else if (!resetn) begin
        chk($sformatf("i%0d_rst_rsp_y", k), 32'(rsp_y[k]), 32'h0);
        chk($sformatf("i%0d_rst_rsp_flags", k), 32'(rsp_flags[k]), 32'h0);
      end
      if (resetn) begin
        if (|(req_valid[k] & req_ready[k])) glog[k].push_back(int'(req_ready[k][1]));
        if (!m_busy[k]) begin
          if (|req_valid[k]) begin
            m_busy[k] = 1'b1; m_age[k] = 0; m_own[k] = pk; m_last[k] = pk;
            if (pk) m_starve[k] = 0;
            else if (req_valid[k][1] && m_starve[k] < 15) m_starve[k]++;
            m_ctrl[k] = op[k][pk]; m_a[k] = opa[k][pk]; m_b[k] = opb[k][pk];
            m_rsp[k] = exp_rsp(op[k][pk], opa[k][pk], opb[k][pk]);
          end
        end else if (m_age[k] >= 2) begin
          if (rsp_ready[k][m_own[k]]) m_busy[k] = 1'b0;
        end else begin
          m_age[k]++;
          if (m_age[k] == 2) m_sreg[k] = m_rsp[k][4:0];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int acc, t, s0, s1;
  logic [1:0] hsb[2];
  int exp_rr[4]  = '{0, 1, 0, 1};
  int exp_fp[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  task automatic send(input int k, input int r, input logic [3:0] o, input logic [15:0] x,
                      input logic [15:0] y, output int a_cyc);
    op[k][r] = o; opa[k][r] = x; opb[k][r] = y; req_valid[k][r] = 1'b1;
    a_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[k][r]) begin a_cyc = cyc + 1; break; end
    end
    if (a_cyc < 0) chk("accept_timeout", 32'(req_ready[k][r]), 32'h1);
    @(posedge clk); #1;
    req_valid[k][r] = 1'b0;
  endtask

  task automatic wait_rsp(input int k, input int r, input bit watch_other, output int r_cyc);
    r_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (watch_other) chk("other_ready_low", 32'(req_ready[k][1-r]), 32'h0);
      if (rsp_valid[k][r]) begin r_cyc = cyc; break; end
    end
    if (r_cyc < 0) chk("rsp_timeout", 32'(rsp_valid[k][r]), 32'h1);
  endtask

  task automatic finish_rsp(input int k, input int r);
    @(posedge clk); #1; rsp_ready[k][r] = 1'b1;
    @(posedge clk); #1; rsp_ready[k][r] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b00; rsp_ready[k] = 2'b00;
      for (int r = 0; r < 2; r++) begin op[k][r] = 4'h0; opa[k][r] = 16'h0; opb[k][r] = 16'h0; end
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Continuous contention: round-robin on instance 0, fixed priority on 1.
    s0 = glog[0].size(); s1 = glog[1].size();
    for (int k = 0; k < 2; k++) begin
      rsp_ready[k] = 2'b11; req_valid[k] = 2'b11;
      for (int r = 0; r < 2; r++) begin op[k][r] = OP_XOR; opa[k][r] = 16'(r + 3); opb[k][r] = 16'hA5A5; end
    end
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (glog[0].size() - s0 >= 4)  req_valid[0] = 2'b00;
      if (glog[1].size() - s1 >= 10) req_valid[1] = 2'b00;
      if (req_valid[0] == 2'b00 && req_valid[1] == 2'b00) break;
    end
    req_valid[0] = 2'b00; req_valid[1] = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), 32'((s0 + i < glog[0].size()) ? glog[0][s0 + i] : -1), 32'(exp_rr[i]));
    for (int i = 0; i < 10; i++)
      chk($sformatf("fp_grant%0d", i), 32'((s1 + i < glog[1].size()) ? glog[1][s1 + i] : -1), 32'(exp_fp[i]));
    rsp_ready[0] = 2'b00; rsp_ready[1] = 2'b00;

    // ADD overflow into the sign bit.
    send(0, 0, OP_ADD, 16'h7FFF, 16'h0001, acc);
    wait_rsp(0, 0, 1'b0, t);
    chk("add_latency", 32'(t - acc), 32'd2);
    chk("add_y", 32'(rsp_y[0]), 32'h8000);
    chk("add_flags", 32'(rsp_flags[0]), 32'(5'b01100));
    chk("add_sreg", 32'(sreg[0]), 32'(5'b01100));
    finish_rsp(0, 0);

    // Requester 1 SUB to zero while requester 0 waits without being granted.
    send(0, 1, OP_SUB, 16'h0005, 16'h0005, acc);
    op[0][0] = OP_XOR; opa[0][0] = 16'h0001; opb[0][0] = 16'h0002; req_valid[0][0] = 1'b1;
    wait_rsp(0, 1, 1'b1, t);
    chk("sub_y", 32'(rsp_y[0]), 32'h0);
    chk("sub_flags", 32'(rsp_flags[0]), 32'(5'b00010));
    finish_rsp(0, 1);
    send(0, 0, OP_XOR, 16'h0001, 16'h0002, acc);
    wait_rsp(0, 0, 1'b0, t);
    chk("xor_y", 32'(rsp_y[0]), 32'h0003);
    finish_rsp(0, 0);

    // MUL with c/v masking, response back-pressured for 5 cycles.
    send(0, 0, OP_MUL, 16'h0100, 16'h0100, acc);
    op[0][1] = OP_SUB; opa[0][1] = 16'h0001; opb[0][1] = 16'h0003; req_valid[0][1] = 1'b1;
    wait_rsp(0, 0, 1'b0, t);
    chk("mul_y", 32'(rsp_y[0]), 32'h0);
    chk("mul_flags", 32'(rsp_flags[0]), 32'(5'b00010));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mul_hold_valid", 32'(rsp_valid[0]), 32'h1);
      chk("mul_hold_y", 32'(rsp_y[0]), 32'h0);
      chk("mul_hold_busy", 32'(busy[0]), 32'h1);
      chk("mul_hold_nogrant", 32'(req_ready[0]), 32'h0);
    end
    finish_rsp(0, 0);
    send(0, 1, OP_SUB, 16'h0001, 16'h0003, acc);
    wait_rsp(0, 1, 1'b0, t);
    chk("subneg_y", 32'(rsp_y[0]), 32'hFFFE);
    chk("subneg_flags", 32'(rsp_flags[0]), 32'(5'b10101));
    finish_rsp(0, 1);

    // Reset while the ALU result is being captured drops the transaction.
    send(0, 0, OP_ADD, 16'h0001, 16'h0001, acc);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("rst_sreg", 32'(sreg[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    send(0, 1, OP_OR, 16'h00F0, 16'h0F00, acc);
    wait_rsp(0, 1, 1'b0, t);
    chk("or_y", 32'(rsp_y[0]), 32'h0FF0);
    chk("or_flags", 32'(rsp_flags[0]), 32'h0);
    finish_rsp(0, 1);

    // Randomized traffic on both instances, including reserved opcodes.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) hsb[k] = req_valid[k] & req_ready[k];
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 2; r++) begin
          if (hsb[k][r] || !req_valid[k][r]) begin
            req_valid[k][r] = (($urandom % 3) != 0);
            op[k][r] = 4'($urandom);
            opa[k][r] = rnd16();
            opb[k][r] = rnd16();
          end
        end
        rsp_ready[k] = 2'($urandom);
      end
    end
    req_valid[0] = 2'b00; req_valid[1] = 2'b00;
    rsp_ready[0] = 2'b11; rsp_ready[1] = 2'b11;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_idle0", 32'(busy[0]), 32'h0);
    chk("drain_idle1", 32'(busy[1]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
